// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: request FSM encodings,
// reset values and RV32 instruction field positions.
package fetch_unit_pkg;

  localparam int          FU_XLEN      = 32;
  localparam logic [31:0] FU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FU_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_STATE_IDLE = 2'd0,
    FETCH_STATE_REQ  = 2'd1,
    FETCH_STATE_WAIT = 2'd2
  } fetch_state_e;

  localparam int INSTR_OPCODE_LSB   = 0;
  localparam int INSTR_OPCODE_WIDTH = 7;
  localparam int INSTR_RD_LSB       = 7;
  localparam int INSTR_REG_WIDTH    = 5;
  localparam int INSTR_FUNCT3_LSB   = 12;
  localparam int INSTR_FUNCT3_WIDTH = 3;
  localparam int INSTR_RS1_LSB      = 15;
  localparam int INSTR_RS2_LSB      = 20;
  localparam int INSTR_FUNCT7_LSB   = 25;
  localparam int INSTR_FUNCT7_WIDTH = 7;

  function automatic logic pc_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = FU_XLEN
);
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemAddr;
  logic            imemRespValid;
  logic [31:0]     imemRespData;

  modport master (
    output imemReqValid,
    output imemAddr,
    input  imemReqReady,
    input  imemRespValid,
    input  imemRespData
  );

  modport slave (
    input  imemReqValid,
    input  imemAddr,
    output imemReqReady,
    output imemRespValid,
    output imemRespData
  );
endinterface

// File: rtl/fetch_unit_imem_req_fsm.sv
// Request/response sequencer for instruction memory: issues one request per
// fetch, holds its address until accepted, and pulses captureEn on the response.
module imem_req_fsm
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = FU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = FU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_irWrite,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_reqReady,
  input  logic            i_respValid,
  output logic            o_reqValid,
  output logic [XLEN-1:0] o_imemAddr,
  output logic [XLEN-1:0] o_reqAddr,
  output logic            o_captureEn
);

  fetch_state_e    r_state;
  fetch_state_e    w_stateNext;
  logic [XLEN-1:0] r_reqAddr;

  // reqAddr is latched only when a new request leaves IDLE, so later PC
  // writes never disturb a transaction already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH_STATE_IDLE;
      r_reqAddr <= RESET_PC;
    end else begin
      r_state <= w_stateNext;
      if (r_state == FETCH_STATE_IDLE && i_irWrite) begin
        r_reqAddr <= i_pc;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    o_reqValid  = 1'b0;
    o_imemAddr  = r_reqAddr;
    o_captureEn = 1'b0;
    unique case (r_state)
      FETCH_STATE_IDLE: begin
        o_reqValid = i_irWrite;
        o_imemAddr = i_pc;
        if (i_irWrite) begin
          w_stateNext = i_reqReady ? FETCH_STATE_WAIT : FETCH_STATE_REQ;
        end
      end
      FETCH_STATE_REQ: begin
        o_reqValid = 1'b1;
        if (i_reqReady) begin
          w_stateNext = FETCH_STATE_WAIT;
        end
      end
      FETCH_STATE_WAIT: begin
        if (i_respValid) begin
          o_captureEn = 1'b1;
          w_stateNext = FETCH_STATE_IDLE;
        end
      end
      default: w_stateNext = FETCH_STATE_IDLE;
    endcase
  end

  assign o_reqAddr = r_reqAddr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and instruction registers, misaligned-PC fault
// flag, fetch counter, and the decoded fields of the current instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = FU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = FU_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = FU_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCWrite,
  input  logic                IRWrite,
  input  logic [XLEN-1:0]     pcNext,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pcOfInstr,
  output logic [31:0]         instr,
  output logic [6:0]          opCode,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic                fetchStall,
  output logic                fetchFault,
  output logic [31:0]         instrCount,
  fetch_unit_if.master        imem
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcOfInstr;
  logic [31:0]     r_instr;
  logic            r_fetchFault;
  logic [31:0]     r_instrCount;
  logic            w_captureEn;
  logic [XLEN-1:0] w_reqAddr;

  imem_req_fsm #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_req_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_irWrite   (IRWrite),
    .i_pc        (r_pc),
    .i_reqReady  (imem.imemReqReady),
    .i_respValid (imem.imemRespValid),
    .o_reqValid  (imem.imemReqValid),
    .o_imemAddr  (imem.imemAddr),
    .o_reqAddr   (w_reqAddr),
    .o_captureEn (w_captureEn)
  );

  // A misaligned target leaves the PC untouched and latches a sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_fetchFault <= 1'b0;
    end else if (PCWrite) begin
      if (pc_aligned(pcNext[1:0])) begin
        r_pc <= pcNext;
      end else begin
        r_fetchFault <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr      <= NOP_INSTR;
      r_pcOfInstr  <= RESET_PC;
      r_instrCount <= 32'd0;
    end else if (w_captureEn) begin
      r_instr      <= imem.imemRespData;
      r_pcOfInstr  <= w_reqAddr;
      r_instrCount <= r_instrCount + 32'd1;
    end
  end

  // Stall drops in the response cycle so the controller leaves FETCH on the IR load edge.
  assign fetchStall = IRWrite && !w_captureEn;

  assign pc         = r_pc;
  assign pcOfInstr  = r_pcOfInstr;
  assign instr      = r_instr;
  assign fetchFault = r_fetchFault;
  assign instrCount = r_instrCount;

  assign opCode = r_instr[INSTR_OPCODE_LSB +: INSTR_OPCODE_WIDTH];
  assign rd     = r_instr[INSTR_RD_LSB     +: INSTR_REG_WIDTH];
  assign rs1    = r_instr[INSTR_RS1_LSB    +: INSTR_REG_WIDTH];
  assign rs2    = r_instr[INSTR_RS2_LSB    +: INSTR_REG_WIDTH];
  assign funct3 = r_instr[INSTR_FUNCT3_LSB +: INSTR_FUNCT3_WIDTH];
  assign funct7 = r_instr[INSTR_FUNCT7_LSB +: INSTR_FUNCT7_WIDTH];

endmodule
